// File: rtl/seq_proc_unit_pkg.sv
// seq_proc_unit_pkg: op encodings, FSM states and PSW bit positions shared by the unit.
// Rev 1.0
`default_nettype none

package seq_proc_unit_pkg;

  typedef enum logic [2:0] {
    OP_RR   = 3'd0,
    OP_RRC  = 3'd1,
    OP_RL   = 3'd2,
    OP_RLC  = 3'd3,
    OP_SWAP = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIV  = 3'd6,
    OP_RSV  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PSW_CY = 7;
  localparam int PSW_AC = 6;
  localparam int PSW_OV = 2;

endpackage

`default_nettype wire

// File: rtl/mul_div_step.sv
// mul_div_step: one unsigned shift-add (MUL) or restoring-subtract (DIV) iteration.
// Rev 1.0
`default_nettype none

module mul_div_step
  import seq_proc_unit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] lo_nxt,
  output logic [DATA_W-1:0] hi_nxt
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    rem_sh = {hi, lo[DATA_W-1]};
    // Remainder is always below the divisor, so the difference fits in DATA_W bits.
    diff   = rem_sh[DATA_W-1:0] - operand;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        hi_nxt = diff;
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[DATA_W:1];
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_proc_unit.sv
// seq_proc_unit: multi-cycle rotate / swap / multiply / divide unit with PSW update.
// Rev 1.0
`default_nettype none

module seq_proc_unit
  import seq_proc_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [CNT_W-1:0]  shamt,
  input  logic [7:0]        psw_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ans,
  output logic [DATA_W-1:0] ans_hi,
  output logic [7:0]        psw_out
);

  localparam int NW = CNT_W + 1;
  localparam int HW = DATA_W / 2;

  state_t            state, state_nxt;
  op_t               op_r;
  logic [DATA_W-1:0] acc_r, hi_r, b_r;
  logic [7:0]        psw_r;
  logic [NW-1:0]     cnt_r, n_r, n_req;
  logic              last_step;

  logic [DATA_W-1:0] md_lo, md_hi;
  logic [DATA_W-1:0] step_acc, step_hi;
  logic              step_cy;
  logic [DATA_W-1:0] res_ans, res_hi;
  logic [7:0]        res_psw;

  always_comb begin
    n_req = NW'(1);
    case (op_t'(op))
      OP_RR, OP_RRC, OP_RL, OP_RLC: n_req = NW'(shamt);
      OP_MUL:                       n_req = NW'(DATA_W);
      OP_DIV:                       n_req = (b_data == '0) ? NW'(1) : NW'(DATA_W);
      default:                      n_req = NW'(1);
    endcase
  end

  assign last_step = (cnt_r + NW'(1)) == n_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (n_req == '0) ? DONE : RUN;
      end
      RUN:  if (last_step) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  mul_div_step #(.DATA_W(DATA_W)) u_step (
    .is_div  (op_r == OP_DIV),
    .lo      (acc_r),
    .hi      (hi_r),
    .operand (b_r),
    .lo_nxt  (md_lo),
    .hi_nxt  (md_hi)
  );

  always_comb begin
    step_acc = acc_r;
    step_hi  = hi_r;
    step_cy  = psw_r[PSW_CY];
    case (op_r)
      OP_RR:   step_acc = {acc_r[0], acc_r[DATA_W-1:1]};
      OP_RRC: begin
        step_acc = {psw_r[PSW_CY], acc_r[DATA_W-1:1]};
        step_cy  = acc_r[0];
      end
      OP_RL:   step_acc = {acc_r[DATA_W-2:0], acc_r[DATA_W-1]};
      OP_RLC: begin
        step_acc = {acc_r[DATA_W-2:0], psw_r[PSW_CY]};
        step_cy  = acc_r[DATA_W-1];
      end
      OP_SWAP: step_acc = {acc_r[HW-1:0], acc_r[DATA_W-1:HW]};
      OP_MUL, OP_DIV: begin
        step_acc = md_lo;
        step_hi  = md_hi;
      end
      default: ;
    endcase
  end

  // Final result as seen through the last step; only loaded into the outputs on that step.
  always_comb begin
    res_ans         = step_acc;
    res_hi          = '0;
    res_psw         = psw_r;
    res_psw[PSW_CY] = step_cy;
    case (op_r)
      OP_MUL: begin
        res_hi          = step_hi;
        res_psw[PSW_CY] = 1'b0;
        res_psw[PSW_OV] = (step_hi != '0);
      end
      OP_DIV: begin
        res_psw[PSW_CY] = 1'b0;
        if (b_r == '0) begin
          res_ans         = '1;
          res_hi          = acc_r;
          res_psw[PSW_OV] = 1'b1;
        end else begin
          res_hi          = step_hi;
          res_psw[PSW_OV] = 1'b0;
        end
      end
      OP_RSV:  res_ans = acc_r;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_RR;
      acc_r   <= '0;
      hi_r    <= '0;
      b_r     <= '0;
      psw_r   <= '0;
      cnt_r   <= '0;
      n_r     <= '0;
      ans     <= '0;
      ans_hi  <= '0;
      psw_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op_t'(op);
            acc_r <= a_data;
            hi_r  <= '0;
            b_r   <= b_data;
            psw_r <= psw_in;
            cnt_r <= '0;
            n_r   <= n_req;
            if (n_req == '0) begin
              ans     <= a_data;
              ans_hi  <= '0;
              psw_out <= psw_in;
            end
          end
        end
        RUN: begin
          acc_r         <= step_acc;
          hi_r          <= step_hi;
          psw_r[PSW_CY] <= step_cy;
          cnt_r         <= cnt_r + NW'(1);
          if (last_step) begin
            ans     <= res_ans;
            ans_hi  <= res_hi;
            psw_out <= res_psw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_proc_unit.sv
// tb_seq_proc_unit: scoreboard bench for seq_proc_unit with DATA_W=8.
// Rev 1.0
`default_nettype none

module tb_seq_proc_unit;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a_data = '0;
  logic [W-1:0]  b_data = '0;
  logic [CW-1:0] shamt = '0;
  logic [7:0]    psw_in = '0;
  logic          busy, done;
  logic [W-1:0]  ans, ans_hi;
  logic [7:0]    psw_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] ans;
    logic [W-1:0] hi;
    logic [7:0]   psw;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb[$];

  seq_proc_unit #(.DATA_W(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a_data  (a_data),
    .b_data  (b_data),
    .shamt   (shamt),
    .psw_in  (psw_in),
    .busy    (busy),
    .done    (done),
    .ans     (ans),
    .ans_hi  (ans_hi),
    .psw_out (psw_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [CW-1:0] sh, input logic [7:0] p);
    exp_t           e;
    logic [W-1:0]   r;
    logic           cy;
    logic [2*W-1:0] prod;
    e.ans = a;
    e.hi  = '0;
    e.psw = p;
    e.lat = 8'd2;
    case (o)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        r  = a;
        cy = p[7];
        for (int i = 0; i < int'(sh); i++) begin
          case (o)
            3'd0:    r = {r[0], r[W-1:1]};
            3'd1:    {r, cy} = {cy, r};
            3'd2:    r = {r[W-2:0], r[W-1]};
            default: {cy, r} = {r, cy};
          endcase
        end
        e.ans    = r;
        e.psw[7] = cy;
        e.lat    = 8'(sh) + 8'd1;
      end
      3'd4: e.ans = {a[3:0], a[7:4]};
      3'd5: begin
        prod     = {8'd0, a} * {8'd0, b};
        e.ans    = prod[W-1:0];
        e.hi     = prod[2*W-1:W];
        e.psw[7] = 1'b0;
        e.psw[2] = (prod[2*W-1:W] != 0);
        e.lat    = 8'd9;
      end
      3'd6: begin
        e.psw[7] = 1'b0;
        if (b == 0) begin
          e.ans    = 8'hFF;
          e.hi     = a;
          e.psw[2] = 1'b1;
        end else begin
          e.ans    = a / b;
          e.hi     = a % b;
          e.psw[2] = 1'b0;
          e.lat    = 8'd9;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [CW-1:0] sh, input logic [7:0] p, input string tag);
    exp_t e;
    int   cyc;
    logic busy_ok;
    sb.push_back(model(o, a, b, sh, p));
    @(negedge clk);
    op = o; a_data = a; b_data = b; shamt = sh; psw_in = p; start = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the operation must use the captured values.
    start = 1'b0; op = 3'($urandom); a_data = 8'($urandom); b_data = 8'($urandom);
    shamt = 3'($urandom); psw_in = 8'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && cyc < 40);
    e = sb.pop_front();
    checks++;
    if (cyc !== int'(e.lat)) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, cyc, e.lat); end
    checks++;
    if (ans !== e.ans) begin errors++; $display("FAIL %s ans got %h want %h", tag, ans, e.ans); end
    checks++;
    if (ans_hi !== e.hi) begin errors++; $display("FAIL %s ans_hi got %h want %h", tag, ans_hi, e.hi); end
    checks++;
    if (psw_out !== e.psw) begin errors++; $display("FAIL %s psw_out got %h want %h", tag, psw_out, e.psw); end
    checks++;
    if (busy_ok !== 1'b1) begin errors++; $display("FAIL %s busy got 0 want 1 during op", tag); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL %s after-done done/busy got %b want 00", tag, {done, busy}); end
    checks++;
    if ({ans, ans_hi, psw_out} !== {e.ans, e.hi, e.psw}) begin
      errors++; $display("FAIL %s hold got %h/%h/%h want %h/%h/%h", tag, ans, ans_hi, psw_out, e.ans, e.hi, e.psw);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, ans, ans_hi, psw_out} !== 26'd0) begin
      errors++; $display("FAIL reset outputs got %b/%b/%h/%h/%h want all 0", busy, done, ans, ans_hi, psw_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_idle busy/done got %b want 00", {busy, done}); end
  endtask

  task automatic test_rotate();
    run_op(3'd2, 8'h81, 8'h00, 3'd3, 8'h00, "rl_81_3");
    run_op(3'd1, 8'h01, 8'h00, 3'd2, 8'h00, "rrc_01_2");
    run_op(3'd1, 8'h01, 8'h00, 3'd1, 8'h00, "rrc_01_1");
    run_op(3'd0, 8'h96, 8'h33, 3'd5, 8'hFF, "rr_96_5");
    run_op(3'd3, 8'h80, 8'h00, 3'd7, 8'h7F, "rlc_80_7");
  endtask

  task automatic test_zero_shift();
    run_op(3'd0, 8'hA5, 8'h00, 3'd0, 8'h85, "rr_zero");
    run_op(3'd3, 8'h3C, 8'h00, 3'd0, 8'h01, "rlc_zero");
  endtask

  task automatic test_swap_rsv();
    run_op(3'd4, 8'hA5, 8'h11, 3'd6, 8'hC4, "swap");
    run_op(3'd7, 8'h3C, 8'h11, 3'd5, 8'h55, "reserved");
  endtask

  task automatic test_mul();
    run_op(3'd5, 8'h50, 8'hA0, 3'd0, 8'h00, "mul_50_a0");
    run_op(3'd5, 8'hFF, 8'hFF, 3'd0, 8'h84, "mul_ff_ff");
    run_op(3'd5, 8'h0F, 8'h03, 3'd0, 8'h04, "mul_small");
  endtask

  task automatic test_div();
    run_op(3'd6, 8'hFB, 8'h12, 3'd0, 8'h00, "div_fb_12");
    run_op(3'd6, 8'h07, 8'h09, 3'd0, 8'h84, "div_7_9");
    run_op(3'd6, 8'hFF, 8'h01, 3'd0, 8'h04, "div_ff_1");
    run_op(3'd6, 8'hFB, 8'h00, 3'd0, 8'h00, "div_by_0");
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    op = 3'd5; a_data = 8'h50; b_data = 8'hA0; shamt = '0; psw_in = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ans, ans_hi, psw_out} !== 26'd0) begin
      errors++; $display("FAIL reset_mid outputs got %b/%b/%h/%h/%h want all 0", busy, done, ans, ans_hi, psw_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid stray activity got %0d cycles want 0", pulses); end
    run_op(3'd5, 8'h50, 8'hA0, 3'd0, 8'h00, "mul_after_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses;
    for (int k = 0; k < 3; k++) sb.push_back(model(3'd2, 8'h81, 8'h00, 3'd3, 8'h00));
    @(negedge clk);
    op = 3'd2; a_data = 8'h81; b_data = 8'h00; shamt = 3'd3; psw_in = 8'h00; start = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 15) start = 1'b0;
      checks++;
      if (done !== ((c % 5) == 4)) begin errors++; $display("FAIL b2b done cycle %0d got %b want %b", c, done, (c % 5) == 4); end
      if (done === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (ans !== e.ans) begin errors++; $display("FAIL b2b ans got %h want %h", ans, e.ans); end
        end
      end
    end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b pulses got %0d want 3", pulses); end
    sb.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 3'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_zero_shift();
    test_swap_rsv();
    test_mul();
    test_div();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/seq_proc_unit.md
SEQ_PROC_UNIT -- requirements
Module: seq_proc_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; even, >= 4.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W), step-counter and shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  0 RR, 1 RRC, 2 RL, 3 RLC, 4 SWAP, 5 MUL, 6 DIV, 7 reserved.
REQ-007 SHALL have port a_data  input  DATA_W  accumulator operand.
REQ-008 SHALL have port b_data  input  DATA_W  B operand (MUL/DIV).
REQ-009 SHALL have port shamt  input  CNT_W  rotate step count (ops 0-3).
REQ-010 SHALL have port psw_in  input  8  PSW at start.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port ans  output  DATA_W  A result (MUL low byte, DIV quotient).
REQ-014 SHALL have port ans_hi  output  DATA_W  B result (MUL high byte, DIV remainder); 0 for ops 0-4 and 7.
REQ-015 SHALL have port psw_out  output  8  updated PSW.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when step counter reaches N, DONE->IDLE unconditionally.
REQ-017 On accept (cycle 0) operands, op and psw_in SHALL be registered; later input changes SHALL have no effect.
REQ-018 Step count N SHALL be: shamt for ops 0-3; 1 for SWAP and op 7; DATA_W for MUL and for DIV with b!=0; 1 for DIV with b=0.
REQ-019 N=0 (shamt=0) SHALL go IDLE->DONE directly, result = a_data, psw unchanged.
REQ-020 done SHALL assert in cycle N+1 (cycle 1 when N=0); busy high cycles 1..N+1.
REQ-021 ans, ans_hi, psw_out SHALL update only in the done cycle and hold until the next done or reset.
REQ-022 start while busy, including in DONE, SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-023 Rotates SHALL move one bit per step; RRC/RLC SHALL rotate through PSW[7] (CY) each step.
REQ-024 SWAP SHALL exchange upper and lower DATA_W/2 halves.
REQ-025 MUL SHALL be unsigned shift-add, one bit per step; CY=0, OV=(ans_hi!=0).
REQ-026 DIV SHALL be unsigned restoring, one quotient bit per step; CY=0, OV=0.
REQ-027 DIV with b=0 SHALL yield ans=all ones, ans_hi=a_data, CY=0, OV=1.
REQ-028 Op 7 SHALL yield ans=a_data, ans_hi=0, psw_out=psw_in.
REQ-029 PSW bits other than CY and OV SHALL pass psw_in through unchanged; OV unchanged for ops 0-4.

Reset
REQ-030 rst_n low SHALL force IDLE and busy=0, done=0, ans=0, ans_hi=0, psw_out=0 immediately, including mid-operation.
REQ-031 An operation interrupted by reset SHALL produce no done pulse after reset release.

Structure
REQ-032 Shared package SHALL hold op encodings, state enum, PSW bit indices (CY=7, AC=6, OV=2).
REQ-033 One combinational sub-module mul_div_step SHALL compute one shift-add/restoring-subtract iteration.

Verification (DATA_W=8)
REQ-034 RL a=0x81 shamt=3 -> done cycle 4, ans=0x0C, ans_hi=0x00.
REQ-035 RRC a=0x01 CY=0 shamt=2 -> done cycle 3, ans=0x80, CY=0; shamt=1 -> ans=0x00, CY=1.
REQ-036 MUL a=0x50 b=0xA0 -> done cycle 9, ans=0x00, ans_hi=0x32, OV=1, CY=0.
REQ-037 DIV a=0xFB b=0x12 -> done cycle 9, ans=0x0D, ans_hi=0x11, OV=0; b=0 -> done cycle 2, ans=0xFF, ans_hi=0xFB, OV=1.
REQ-038 MUL started, rst_n low at cycle 4 -> outputs 0, busy=0, no done; new start after release completes normally.
REQ-039 start held high throughout -> next accepted cycle after done, done pulses exactly once per operation.
